// File: rtl/multi_counter_wb.sv
// multi_counter_wb: Wishbone-mapped bank of NCH up/down counters with compare match, one-shot and IRQ
module multi_counter_wb #(
  parameter int NCH = 4,
  parameter int WIDTH = 16,
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [31:0]          wbs_dat_i,
  output logic                 wbs_ack_o,
  output logic [31:0]          wbs_dat_o,
  input  logic [NCH-1:0]       la_load_i,
  input  logic [WIDTH-1:0]     la_value_i,
  output logic [NCH*WIDTH-1:0] count_o,
  output logic [NCH-1:0]       irq_o
);
  logic [31:0] off, rd_d, lane_m;
  logic [3:0] ch;
  logic [1:0] rg;
  logic valid, acc, wr, unused_ok;
  logic [NCH*4-1:0] ctrl_a;
  logic [NCH*WIDTH-1:0] cmp_a;
  logic [NCH-1:0] match_a;
  assign off = wbs_adr_i - ADDR_BASE;
  assign ch = off[7:4];
  assign rg = off[3:2];
  assign valid = wbs_cyc_i && wbs_stb_i && wbs_adr_i >= ADDR_BASE && off < 32'(NCH * 16);
  assign acc = valid && !wbs_ack_o;
  assign wr = acc && wbs_we_i;
  assign lane_m = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign unused_ok = ^{lane_m, wbs_dat_i};
  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] cur);
    return (wbs_dat_i[WIDTH-1:0] & lane_m[WIDTH-1:0]) | (cur & ~lane_m[WIDTH-1:0]);
  endfunction
  always_comb begin
    rd_d = '0;
    for (int i = 0; i < NCH; i++)
      if (ch == 4'(i))
        rd_d = rg == 2'd0 ? 32'(ctrl_a[i*4 +: 4]) : rg == 2'd1 ? 32'(count_o[i*WIDTH +: WIDTH]) :
               rg == 2'd2 ? 32'(cmp_a[i*WIDTH +: WIDTH]) : 32'(match_a[i]);
  end
  always_ff @(posedge wb_clk_i)
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= acc;
      wbs_dat_o <= acc && !wbs_we_i ? rd_d : '0;
    end
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [3:0] ctrl_q;
    logic [WIDTH-1:0] cnt_q, cmp_q, step;
    logic match_q, sel_c, hit;
    assign sel_c = wr && ch == 4'(c);
    assign step = ctrl_q[1] ? cnt_q - WIDTH'(1) : cnt_q + WIDTH'(1);
    // a step pre-empted by a bus or LA load never counts as a match
    assign hit = ctrl_q[0] && !(sel_c && rg == 2'd1) && !la_load_i[c] && step == cmp_q;
    always_ff @(posedge wb_clk_i)
      if (!wb_rst_ni) begin
        ctrl_q <= '0;
        cnt_q <= '0;
        cmp_q <= '0;
        match_q <= 1'b0;
      end else begin
        if (sel_c && rg == 2'd0) ctrl_q <= wbs_sel_i[0] ? wbs_dat_i[3:0] : ctrl_q;
        else if (hit && ctrl_q[2]) ctrl_q[0] <= 1'b0;
        if (sel_c && rg == 2'd1) cnt_q <= merge(cnt_q);
        else if (la_load_i[c]) cnt_q <= la_value_i;
        else if (ctrl_q[0]) cnt_q <= step;
        if (sel_c && rg == 2'd2) cmp_q <= merge(cmp_q);
        if (hit) match_q <= 1'b1;
        else if (sel_c && rg == 2'd3 && wbs_sel_i[0] && wbs_dat_i[0]) match_q <= 1'b0;
      end
    assign ctrl_a[c*4 +: 4] = ctrl_q;
    assign cmp_a[c*WIDTH +: WIDTH] = cmp_q;
    assign match_a[c] = match_q;
    assign count_o[c*WIDTH +: WIDTH] = cnt_q;
    assign irq_o[c] = match_q && ctrl_q[3];
  end
endmodule

// File: tb/tb_multi_counter_wb.sv
// tb_multi_counter_wb: scoreboard bench with a cycle-level behavioural model of the counter bank
module tb_multi_counter_wb;
  localparam int NCH = 4;
  localparam int WIDTH = 16;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam longint M = 64'd1 << WIDTH;
  logic clk = 1'b0, rst_n = 1'b0, cyc = 1'b0, stb = 1'b0, we = 1'b0, ack;
  logic [3:0] sel = '0;
  logic [31:0] adr = '0, dat = '0, dato;
  logic [NCH-1:0] la_load = '0, irq;
  logic [WIDTH-1:0] la_val = '0;
  logic [NCH*WIDTH-1:0] count;
  int checks = 0, errors = 0;
  int unsigned m_cnt [NCH], m_cmp [NCH];
  bit [3:0] m_ctrl [NCH];
  bit m_match [NCH];
  bit m_ack = 1'b0, mon_on = 1'b0;
  logic [31:0] exp_q [$];

  multi_counter_wb #(.NCH(NCH), .WIDTH(WIDTH), .ADDR_BASE(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dato),
    .la_load_i(la_load), .la_value_i(la_val), .count_o(count), .irq_o(irq));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int unsigned wmerge(input int unsigned cur, input logic [31:0] d, input logic [3:0] s);
    longint r = 0;
    for (int b = 0; b < 4; b++)
      r = r | (longint'(s[b] ? ((d >> (8*b)) & 32'hFF) : ((cur >> (8*b)) & 32'hFF)) << (8*b));
    return 32'(r % M);
  endfunction

  // reference model: one update per clock edge from the register-level rules
  always @(posedge clk) begin
    logic [31:0] o;
    int c, r;
    bit acc, w, hit;
    int unsigned nxt;
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        m_cnt[i] = 0; m_cmp[i] = 0; m_ctrl[i] = 0; m_match[i] = 0;
      end
      m_ack = 0;
    end else begin
      o = adr - BASE;
      acc = cyc && stb && !m_ack && adr >= BASE && o < NCH * 16;
      c = int'(o[7:4]);
      r = int'(o[3:2]);
      if (acc)
        exp_q.push_back(we ? 32'd0 : r == 0 ? 32'(m_ctrl[c]) : r == 1 ? m_cnt[c] :
                        r == 2 ? m_cmp[c] : 32'(m_match[c]));
      for (int i = 0; i < NCH; i++) begin
        w = acc && we && c == i;
        nxt = m_ctrl[i][1] ? 32'((longint'(m_cnt[i]) + M - 1) % M) : 32'((longint'(m_cnt[i]) + 1) % M);
        hit = m_ctrl[i][0] && !(w && r == 1) && !la_load[i] && nxt == m_cmp[i];
        if (w && r == 1) m_cnt[i] = wmerge(m_cnt[i], dat, sel);
        else if (la_load[i]) m_cnt[i] = 32'(la_val);
        else if (m_ctrl[i][0]) m_cnt[i] = nxt;
        if (w && r == 0) begin
          if (sel[0]) m_ctrl[i] = dat[3:0];
        end else if (hit && m_ctrl[i][2]) m_ctrl[i][0] = 1'b0;
        if (w && r == 2) m_cmp[i] = wmerge(m_cmp[i], dat, sel);
        if (hit) m_match[i] = 1'b1;
        else if (w && r == 3 && sel[0] && dat[0]) m_match[i] = 1'b0;
      end
      m_ack = acc;
    end
  end

  // monitor: pops expected read data whenever the DUT acks
  always @(negedge clk) if (mon_on) begin
    chk("ack", 64'(ack), 64'(m_ack));
    if (ack) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rdata_unexpected actual=%0h required=no_ack", dato);
      end else chk("rdata", 64'(dato), 64'(exp_q.pop_front()));
    end else chk("dat_idle", 64'(dato), 64'd0);
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("count%0d", i), 64'(count[i*WIDTH +: WIDTH]), 64'(m_cnt[i]));
      chk($sformatf("irq%0d", i), 64'(irq[i]), 64'(m_match[i] & m_ctrl[i][3]));
    end
  end

  task automatic wb(input bit w, input int c, input int r, input logic [31:0] d, input logic [3:0] s, output bit got);
    cyc = 1; stb = 1; we = w; adr = BASE + 32'(c * 16 + r * 4); dat = d; sel = s; got = 0;
    for (int n = 0; n < 4 && !got; n++) begin
      @(posedge clk); #1;
      got = ack;
    end
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wr(input int c, input int r, input logic [31:0] d);
    bit g;
    wb(1, c, r, d, 4'hF, g);
  endtask

  task automatic rd(input int c, input int r);
    bit g;
    wb(0, c, r, 32'd0, 4'hF, g);
  endtask

  task automatic expect_cnt(input int c, input int unsigned v);
    chk($sformatf("dir_cnt%0d", c), 64'(count[c*WIDTH +: WIDTH]), 64'(v));
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  initial begin
    bit got;
    int n;
    tick;
    mon_on = 1;
    tick; tick;
    rst_n = 1;
    for (int c = 0; c < NCH; c++) for (int r = 0; r < 4; r++) rd(c, r);
    chk("irq_reset", 64'(irq), 64'd0);
    // ch0 compare match with IRQ
    wr(0, 2, 5);
    wr(0, 0, 32'h9);
    for (int k = 0; k < 10 && count[15:0] != 16'd5; k++) tick;
    expect_cnt(0, 5);
    chk("irq0_match", 64'(irq[0]), 64'd1);
    tick; expect_cnt(0, 6);
    tick; expect_cnt(0, 7);
    wr(0, 3, 1);
    chk("irq0_clear", 64'(irq[0]), 64'd0);
    wr(0, 0, 0);
    // ch1 down-counter wrap
    wr(1, 1, 1);
    wr(1, 0, 32'h3);
    expect_cnt(1, 1);
    tick; expect_cnt(1, 0);
    tick; expect_cnt(1, 16'hFFFF);
    tick; expect_cnt(1, 16'hFFFE);
    wr(1, 0, 0);
    // ch2 one-shot
    wr(2, 2, 3);
    wr(2, 0, 32'h5);
    repeat (6) tick;
    expect_cnt(2, 3);
    rd(2, 0);
    rd(2, 3);
    // ch3 load priority
    wr(3, 2, 32'h1234);
    wr(3, 0, 32'h8);
    la_load = 4'b1000; la_val = 16'h1234;
    wr(3, 1, 32'h00AA);
    la_load = 0;
    expect_cnt(3, 16'h00AA);
    la_load = 4'b1000;
    tick;
    la_load = 0;
    expect_cnt(3, 16'h1234);
    chk("irq3_la", 64'(irq[3]), 64'd0);
    rd(3, 3);
    // byte lanes and window
    wr(0, 1, 0);
    wb(1, 0, 1, 32'hABCD, 4'b0010, got);
    expect_cnt(0, 16'hAB00);
    rd(0, 1);
    wb(0, NCH, 0, 0, 4'hF, got);
    chk("oow_ack", 64'(got), 64'd0);
    // strobe held: ack every other cycle
    cyc = 1; stb = 1; we = 0; adr = BASE + 32'd4; n = 0;
    repeat (6) begin tick; n += int'(ack); end
    cyc = 0; stb = 0;
    chk("b2b_acks", 64'(n), 64'd3);
    // randomized traffic
    for (int t = 0; t < 400; t++) begin
      int c, r;
      logic [31:0] d;
      la_load = $urandom_range(0, 7) == 0 ? 4'($urandom) : 4'd0;
      la_val = 16'($urandom_range(0, 24));
      c = $urandom_range(0, 19) == 0 ? NCH : int'($urandom_range(0, NCH - 1));
      r = int'($urandom_range(0, 3));
      d = r == 0 ? 32'($urandom_range(0, 15)) : r == 3 ? $urandom : 32'($urandom_range(0, 24));
      if ($urandom_range(0, 7) == 0) d = $urandom;
      wb(1'($urandom), c, r, d, 4'($urandom), got);
      la_load = 0;
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) tick;
    end
    // reset while a write is being strobed
    wr(0, 0, 32'h1);
    cyc = 1; stb = 1; we = 1; adr = BASE + 32'd4; dat = 32'h55; sel = 4'hF;
    rst_n = 0;
    tick;
    chk("rst_ack", 64'(ack), 64'd0);
    rst_n = 1; cyc = 0; stb = 0; we = 0;
    expect_cnt(0, 0);
    repeat (3) tick;
    chk("q_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
